// File: rtl/control_unit.sv
// Multi-cycle control unit for the K&S datapath: fetch/decode/execute FSM,
// registered ALU flags for branch decisions and a saturating fetch counter.
package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE,
    I_ADD, I_SUB, I_AND, I_OR,
    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
    I_BNNEG, I_BOV, I_BNOV, I_HALT
  } decoded_instruction_type;
endpackage

module control_unit
  import k_and_s_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic [1:0]              operation,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic [CNT_W-1:0]        instr_count
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_ALU, S_EXEC_MOVE, S_EXEC_STORE,
    S_LOAD_ADDR, S_LOAD_WB, S_EXEC_BRANCH, S_HALT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_flags;
  logic [CNT_W-1:0] r_cnt;
  logic             w_taken;
  logic             w_unused_sov;

  logic       w_branch, w_pc_en, w_ir_en, w_addr_sel, w_c_sel;
  logic       w_wr_en, w_fl_en, w_ram_we, w_halt;
  logic [1:0] w_op;

  // SOV is kept for the datapath's flag model but no branch tests it
  assign w_unused_sov = r_flags[0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_flags <= 4'b0000;
    else if (w_fl_en)
      r_flags <= {zero_op, neg_op, unsigned_overflow, signed_overflow};
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (r_state == S_FETCH && r_cnt != {CNT_W{1'b1}})
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_comb begin
    w_taken = 1'b0;
    case (decoded_instruction)
      I_BRANCH: w_taken = 1'b1;
      I_BZERO:  w_taken = r_flags[3];
      I_BNZERO: w_taken = !r_flags[3];
      I_BNEG:   w_taken = r_flags[2];
      I_BNNEG:  w_taken = !r_flags[2];
      I_BOV:    w_taken = r_flags[1];
      I_BNOV:   w_taken = !r_flags[1];
      default:  w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (decoded_instruction)
          I_ADD, I_SUB, I_AND, I_OR: w_next = S_EXEC_ALU;
          I_MOVE:                    w_next = S_EXEC_MOVE;
          I_STORE:                   w_next = S_EXEC_STORE;
          I_LOAD:                    w_next = S_LOAD_ADDR;
          I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
          I_BNNEG, I_BOV, I_BNOV:    w_next = S_EXEC_BRANCH;
          I_HALT:                    w_next = S_HALT;
          default:                   w_next = S_FETCH;
        endcase
      end
      S_LOAD_ADDR: w_next = S_LOAD_WB;
      S_HALT:      w_next = S_HALT;
      default:     w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_branch   = 1'b0;
    w_pc_en    = 1'b0;
    w_ir_en    = 1'b0;
    w_addr_sel = 1'b0;
    w_c_sel    = 1'b0;
    w_wr_en    = 1'b0;
    w_fl_en    = 1'b0;
    w_op       = 2'b00;
    w_ram_we   = 1'b0;
    w_halt     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_en = 1'b1;
        w_pc_en = 1'b1;
      end
      S_EXEC_ALU: begin
        w_wr_en = 1'b1;
        w_fl_en = 1'b1;
        case (decoded_instruction)
          I_AND:   w_op = 2'b01;
          I_OR:    w_op = 2'b10;
          I_SUB:   w_op = 2'b11;
          default: w_op = 2'b00;
        endcase
      end
      S_EXEC_MOVE: begin
        w_op    = 2'b01;
        w_wr_en = 1'b1;
      end
      S_EXEC_STORE: begin
        w_addr_sel = 1'b1;
        w_ram_we   = 1'b1;
      end
      S_LOAD_ADDR: w_addr_sel = 1'b1;
      S_LOAD_WB: begin
        w_addr_sel = 1'b1;
        w_c_sel    = 1'b1;
        w_wr_en    = 1'b1;
      end
      S_EXEC_BRANCH: begin
        w_branch = w_taken;
        w_pc_en  = w_taken;
      end
      S_HALT:  w_halt = 1'b1;
      default: ;
    endcase
  end

  // Reset overrides decode so nothing strobes while rst is held
  assign branch           = w_branch   & !rst;
  assign pc_enable        = w_pc_en    & !rst;
  assign ir_enable        = w_ir_en    & !rst;
  assign addr_sel         = w_addr_sel & !rst;
  assign c_sel            = w_c_sel    & !rst;
  assign write_reg_enable = w_wr_en    & !rst;
  assign flags_reg_enable = w_fl_en    & !rst;
  assign operation        = rst ? 2'b00 : w_op;
  assign ram_write_enable = w_ram_we   & !rst;
  assign halt             = w_halt     & !rst;
  assign instr_count      = r_cnt;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: instruction-level reference model feeds
// expected per-cycle controls; a negedge monitor compares.
module tb_control_unit;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  decoded_instruction_type instr = I_NOP;
  logic zero_op = 1'b0;
  logic neg_op = 1'b0;
  logic unsigned_overflow = 1'b0;
  logic signed_overflow = 1'b0;

  logic        branch, pc_enable, ir_enable, addr_sel, c_sel;
  logic        write_reg_enable, flags_reg_enable, ram_write_enable, halt;
  logic [1:0]  operation;
  logic [15:0] instr_count;

  logic        b4, pc4, ir4, as4, cs4, wr4, fe4, rw4, h4;
  logic [1:0]  op4;
  logic [3:0]  cnt4;

  control_unit #(.CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .decoded_instruction(instr),
    .zero_op(zero_op), .neg_op(neg_op),
    .unsigned_overflow(unsigned_overflow),
    .signed_overflow(signed_overflow),
    .branch(branch), .pc_enable(pc_enable), .ir_enable(ir_enable),
    .addr_sel(addr_sel), .c_sel(c_sel),
    .write_reg_enable(write_reg_enable),
    .flags_reg_enable(flags_reg_enable), .operation(operation),
    .ram_write_enable(ram_write_enable), .halt(halt),
    .instr_count(instr_count)
  );

  control_unit #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .decoded_instruction(instr),
    .zero_op(zero_op), .neg_op(neg_op),
    .unsigned_overflow(unsigned_overflow),
    .signed_overflow(signed_overflow),
    .branch(b4), .pc_enable(pc4), .ir_enable(ir4),
    .addr_sel(as4), .c_sel(cs4), .write_reg_enable(wr4),
    .flags_reg_enable(fe4), .operation(op4),
    .ram_write_enable(rw4), .halt(h4), .instr_count(cnt4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] ctl;
    bit          cv;
    int unsigned cnt;
    int unsigned cnt4;
  } rec_t;

  rec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int unsigned m_cnt = 0;
  int unsigned m_cnt4 = 0;
  bit mz, mn, mu, ms;

  logic [10:0] w_act;
  logic [10:0] w_act4;
  assign w_act = {branch, pc_enable, ir_enable, addr_sel, c_sel,
                  write_reg_enable, flags_reg_enable, operation,
                  ram_write_enable, halt};
  assign w_act4 = {b4, pc4, ir4, as4, cs4, wr4, fe4, op4, rw4, h4};

  function automatic logic [10:0] mk(
    bit br, bit pc, bit ir, bit as, bit cs, bit wr, bit fe,
    logic [1:0] op, bit rw, bit ht);
    return {br, pc, ir, as, cs, wr, fe, op, rw, ht};
  endfunction

  function automatic logic [1:0] alu_code(decoded_instruction_type op);
    case (op)
      I_AND:   return 2'b01;
      I_OR:    return 2'b10;
      I_SUB:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic bit taken(decoded_instruction_type op);
    case (op)
      I_BRANCH: return 1'b1;
      I_BZERO:  return mz;
      I_BNZERO: return !mz;
      I_BNEG:   return mn;
      I_BNNEG:  return !mn;
      I_BOV:    return mu;
      I_BNOV:   return !mu;
      default:  return 1'b0;
    endcase
  endfunction

  // One clock of stimulus; zf >= 0 pins zero_op for directed cases
  task automatic cyc(input logic [10:0] ctl, input bit r, input bit cv,
                     input decoded_instruction_type op, input int zf,
                     output logic [3:0] live);
    rec_t e;
    @(posedge clk);
    #1;
    live = 4'($urandom);
    if (zf >= 0) live[3] = zf[0];
    rst = r;
    instr = op;
    {zero_op, neg_op, unsigned_overflow, signed_overflow} = live;
    e.ctl = ctl;
    e.cv = cv;
    e.cnt = m_cnt;
    e.cnt4 = m_cnt4;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_cnt4 = 0;
    {mz, mn, mu, ms} = 4'b0000;
  endtask

  task automatic reset_cycle(input decoded_instruction_type op);
    logic [3:0] lv;
    cyc(11'd0, 1'b1, 1'b0, op, -1, lv);
    model_reset();
  endtask

  task automatic do_instr(input decoded_instruction_type op, input int zf,
                          input bit rst_mid_load);
    logic [3:0] lv;
    cyc(mk(0,1,1,0,0,0,0,2'b00,0,0), 1'b0, 1'b1, op, zf, lv);
    if (m_cnt < 65535) m_cnt++;
    if (m_cnt4 < 15) m_cnt4++;
    cyc(11'd0, 1'b0, 1'b1, op, zf, lv);
    case (op)
      I_ADD, I_SUB, I_AND, I_OR: begin
        cyc(mk(0,0,0,0,0,1,1,alu_code(op),0,0), 1'b0, 1'b1, op, zf, lv);
        {mz, mn, mu, ms} = lv;
      end
      I_MOVE:
        cyc(mk(0,0,0,0,0,1,0,2'b01,0,0), 1'b0, 1'b1, op, zf, lv);
      I_STORE:
        cyc(mk(0,0,0,1,0,0,0,2'b00,1,0), 1'b0, 1'b1, op, zf, lv);
      I_LOAD: begin
        if (rst_mid_load) begin
          reset_cycle(op);
        end else begin
          cyc(mk(0,0,0,1,0,0,0,2'b00,0,0), 1'b0, 1'b1, op, zf, lv);
          cyc(mk(0,0,0,1,1,1,0,2'b00,0,0), 1'b0, 1'b1, op, zf, lv);
        end
      end
      I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
        bit t;
        t = taken(op);
        cyc(mk(t,t,0,0,0,0,0,2'b00,0,0), 1'b0, 1'b1, op, zf, lv);
      end
      I_HALT: begin
        for (int i = 0; i < 20; i++)
          cyc(mk(0,0,0,0,0,0,0,2'b00,0,1), 1'b0, 1'b1,
              decoded_instruction_type'($urandom_range(0, 15)), -1, lv);
        reset_cycle(op);
      end
      default: ;
    endcase
  endtask

  rec_t e;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (w_act !== e.ctl) begin
        errors++;
        $display("FAIL ctl t=%0t got %b exp %b", $time, w_act, e.ctl);
      end
      checks++;
      if (w_act4 !== e.ctl) begin
        errors++;
        $display("FAIL ctl4 t=%0t got %b exp %b", $time, w_act4, e.ctl);
      end
      if (e.cv) begin
        checks++;
        if (instr_count !== e.cnt[15:0]) begin
          errors++;
          $display("FAIL instr_count t=%0t got %0d exp %0d",
                   $time, instr_count, e.cnt);
        end
        checks++;
        if (cnt4 !== e.cnt4[3:0]) begin
          errors++;
          $display("FAIL instr_count4 t=%0t got %0d exp %0d",
                   $time, cnt4, e.cnt4);
        end
      end
    end
  end

  initial begin
    decoded_instruction_type op;
    reset_cycle(I_NOP);
    reset_cycle(I_NOP);
    do_instr(I_ADD, -1, 1'b0);
    do_instr(I_LOAD, -1, 1'b0);
    do_instr(I_SUB, 1, 1'b0);
    do_instr(I_BZERO, -1, 1'b0);
    do_instr(I_SUB, 0, 1'b0);
    do_instr(I_BZERO, -1, 1'b0);
    do_instr(I_SUB, 1, 1'b0);
    do_instr(I_MOVE, 0, 1'b0);
    do_instr(I_BZERO, -1, 1'b0);
    for (int i = 0; i < 20; i++) do_instr(I_NOP, -1, 1'b0);
    do_instr(I_LOAD, -1, 1'b1);
    do_instr(I_BNZERO, -1, 1'b0);
    do_instr(I_HALT, -1, 1'b0);
    do_instr(I_BZERO, -1, 1'b0);
    for (int i = 0; i < 400; i++) begin
      op = decoded_instruction_type'($urandom_range(0, 15));
      do_instr(op, -1, (op == I_LOAD) && ($urandom_range(0, 3) == 0));
    end
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
